// File: rtl/lockstep_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lockstep_pkg
//  Purpose : Shared constants for the instruction-level lockstep scheduler.
//            Holds the controller state encoding and the default wait limit.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package lockstep_pkg;

  // Controller states. Kept as plain sized constants so older tools that
  // choke on enum casts can still read the state register directly.
  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_WAIT_A  = 3'd1;  // A parked at a boundary, B still running
  localparam logic [2:0] S_WAIT_B  = 3'd2;  // B parked at a boundary, A still running
  localparam logic [2:0] S_ALIGN   = 3'd3;  // both parked, compare window
  localparam logic [2:0] S_RELEASE = 3'd4;  // one-cycle joint step off the boundary
  localparam logic [2:0] S_HALT    = 3'd5;  // terminal until reset

  typedef logic [2:0] state_t;

  // Cycles one core may sit at a boundary waiting for its partner.
  localparam int DEFAULT_TIMEOUT = 64;

endpackage : lockstep_pkg
`default_nettype wire

// File: rtl/lockstep_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module  : lockstep_wait_timer
//  Purpose : Loadable down-counter with an expiry flag. Loaded with LOAD when
//            a wait begins; counts down once per waiting cycle; o_expired is
//            high while the count is zero (the last permitted waiting cycle).
//  Ports   : clk        system clock
//            rst_n      asynchronous active-low reset
//            i_load     reload the counter with LOAD (wins over i_dec)
//            i_dec      decrement by one (holds at zero)
//            o_expired  count is zero
//  Rev     : 1.0  initial release
// ============================================================================
module lockstep_wait_timer #(
  parameter int WIDTH = 7,
  parameter int LOAD  = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= WIDTH'(LOAD);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule : lockstep_wait_timer
`default_nettype wire

// File: rtl/lockstep_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : lockstep_sync_ctrl
//  Purpose : Instruction-level lockstep scheduler for a dual-core equivalence
//            harness. Gates each core's clock enable so it parks at its next
//            instruction boundary, compares PC/instruction once both are
//            parked, raises a compare window, then releases both together.
//  Ports   : clk           system clock
//            resetn        asynchronous active-low reset
//            a/b_inst_start core at instruction boundary (level)
//            a/b_pc        core PC
//            a/b_instr     core current instruction word
//            a/b_en        core clock enables (combinational)
//            cmp_valid     both cores frozen at an aligned, matching boundary
//            cmp_pc        PC captured at the latest alignment
//            align_cnt     completed alignments (saturating)
//            err_mismatch  sticky PC/instruction difference
//            err_timeout   sticky partner-wait overrun
//            halted        controller in HALT
//  Rev     : 1.0  initial release
// ============================================================================
module lockstep_sync_ctrl
  import lockstep_pkg::*;
#(
  parameter int TIMEOUT          = DEFAULT_TIMEOUT,
  parameter int CMP_CYCLES       = 2,
  parameter int WARMUP           = 2,
  parameter int CNT_W            = 16,
  parameter int STOP_ON_MISMATCH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             a_inst_start,
  input  logic             b_inst_start,
  input  logic [31:0]      a_pc,
  input  logic [31:0]      b_pc,
  input  logic [31:0]      a_instr,
  input  logic [31:0]      b_instr,
  output logic             a_en,
  output logic             b_en,
  output logic             cmp_valid,
  output logic [31:0]      cmp_pc,
  output logic [CNT_W-1:0] align_cnt,
  output logic             err_mismatch,
  output logic             err_timeout,
  output logic             halted
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = (CMP_CYCLES < 2) ? 1 : $clog2(CMP_CYCLES);
  localparam int WARM_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  state_t              r_state;
  state_t              w_next;
  logic [HOLD_W-1:0]   r_hold;
  logic [WARM_W-1:0]   r_warm;
  logic                r_cur_mis;   // mismatch seen at the alignment in progress
  logic                r_cmp_ok;    // this alignment may raise cmp_valid
  logic [31:0]         r_cmp_pc;
  logic [CNT_W-1:0]    r_align_cnt;
  logic                r_err_mis;
  logic                r_err_to;

  logic w_in_wait;
  logic w_partner;
  logic w_expired;
  logic w_timeout;
  logic w_load;
  logic w_dec;
  logic w_hold_last;
  logic w_enter_align;
  logic w_mis;

  // ---- wait timer, shared by both WAIT states ----
  assign w_in_wait = (r_state == S_WAIT_A) || (r_state == S_WAIT_B);
  assign w_partner = (r_state == S_WAIT_A) ? b_inst_start : a_inst_start;
  assign w_load    = (r_state == S_RUN) && (a_inst_start ^ b_inst_start);
  assign w_dec     = w_in_wait && !w_partner;
  // The timer is loaded with TIMEOUT-1 so it reads zero on the TIMEOUT-th
  // waiting cycle; a partner arriving on that very cycle still wins.
  assign w_timeout = w_in_wait && !w_partner && w_expired;

  lockstep_wait_timer #(
    .WIDTH (TMR_W),
    .LOAD  (TIMEOUT - 1)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (resetn),
    .i_load    (w_load),
    .i_dec     (w_dec),
    .o_expired (w_expired)
  );

  assign w_hold_last   = (r_hold == HOLD_W'(CMP_CYCLES - 1));
  assign w_mis         = (a_pc != b_pc) || (a_instr != b_instr);
  assign w_enter_align = (w_next == S_ALIGN) && (r_state != S_ALIGN);

  // ---- next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        if (a_inst_start && b_inst_start) w_next = S_ALIGN;
        else if (a_inst_start)            w_next = S_WAIT_A;
        else if (b_inst_start)            w_next = S_WAIT_B;
      end
      S_WAIT_A, S_WAIT_B: begin
        if (w_partner)      w_next = S_ALIGN;
        else if (w_expired) w_next = S_HALT;
      end
      S_ALIGN: begin
        if (w_hold_last) begin
          w_next = (r_cur_mis && (STOP_ON_MISMATCH != 0)) ? S_HALT : S_RELEASE;
        end
      end
      S_RELEASE: w_next = S_RUN;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_RUN;
    endcase
  end

  // ---- clock enables: combinational so the boundary cycle itself is gated ----
  always_comb begin
    a_en = 1'b0;
    b_en = 1'b0;
    case (r_state)
      S_RUN: begin
        a_en = !a_inst_start;
        b_en = !b_inst_start;
      end
      S_WAIT_A: b_en = !b_inst_start;
      S_WAIT_B: a_en = !a_inst_start;
      S_RELEASE: begin
        a_en = 1'b1;
        b_en = 1'b1;
      end
      default: begin
        a_en = 1'b0;
        b_en = 1'b0;
      end
    endcase
  end

  // ---- state, capture and counters ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_RUN;
      r_hold      <= '0;
      r_warm      <= '0;
      r_cur_mis   <= 1'b0;
      r_cmp_ok    <= 1'b0;
      r_cmp_pc    <= '0;
      r_align_cnt <= '0;
      r_err_mis   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_timeout) begin
        r_err_to <= 1'b1;
      end

      if (w_enter_align) begin
        r_hold    <= '0;
        r_cmp_pc  <= a_pc;
        r_cur_mis <= w_mis;
        // Window is opened only once the reset-vector skew has been absorbed.
        r_cmp_ok  <= (r_warm == WARM_W'(WARMUP)) && !w_mis;
        if (w_mis) begin
          r_err_mis <= 1'b1;
        end
        if (r_warm != WARM_W'(WARMUP)) begin
          r_warm <= r_warm + WARM_W'(1);
        end
        if (r_align_cnt != '1) begin
          r_align_cnt <= r_align_cnt + CNT_W'(1);
        end
      end else if ((r_state == S_ALIGN) && !w_hold_last) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign cmp_valid    = (r_state == S_ALIGN) && r_cmp_ok;
  assign cmp_pc       = r_cmp_pc;
  assign align_cnt    = r_align_cnt;
  assign err_mismatch = r_err_mis;
  assign err_timeout  = r_err_to;
  assign halted       = (r_state == S_HALT);

endmodule : lockstep_sync_ctrl
`default_nettype wire

// File: tb/tb_lockstep_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lockstep_sync_ctrl
//  Purpose : Self-checking bench for lockstep_sync_ctrl. Two instances share
//            one stimulus stream: u_dut0 with the default parameters and
//            u_dut1 with a short timeout, single-cycle window, no warm-up,
//            4-bit counter and no stop on mismatch. A behavioural model of
//            each is stepped every clock and compared on every negedge.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lockstep_sync_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        as, bs;
  logic [31:0] apc, bpc, ai, bi;

  logic        a_en0, b_en0, cv0, em0, et0, h0;
  logic [31:0] cpc0;
  logic [15:0] cnt0;
  logic        a_en1, b_en1, cv1, em1, et1, h1;
  logic [31:0] cpc1;
  logic [3:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lockstep_sync_ctrl #(
    .TIMEOUT(64), .CMP_CYCLES(2), .WARMUP(2), .CNT_W(16), .STOP_ON_MISMATCH(1)
  ) u_dut0 (
    .clk(clk), .resetn(resetn),
    .a_inst_start(as), .b_inst_start(bs),
    .a_pc(apc), .b_pc(bpc), .a_instr(ai), .b_instr(bi),
    .a_en(a_en0), .b_en(b_en0), .cmp_valid(cv0), .cmp_pc(cpc0),
    .align_cnt(cnt0), .err_mismatch(em0), .err_timeout(et0), .halted(h0)
  );

  lockstep_sync_ctrl #(
    .TIMEOUT(8), .CMP_CYCLES(1), .WARMUP(0), .CNT_W(4), .STOP_ON_MISMATCH(0)
  ) u_dut1 (
    .clk(clk), .resetn(resetn),
    .a_inst_start(as), .b_inst_start(bs),
    .a_pc(apc), .b_pc(bpc), .a_instr(ai), .b_instr(bi),
    .a_en(a_en1), .b_en(b_en1), .cmp_valid(cv1), .cmp_pc(cpc1),
    .align_cnt(cnt1), .err_mismatch(em1), .err_timeout(et1), .halted(h1)
  );

  // ---------------------------------------------------------------------
  // Behavioural model. ph: 0 free-running, 1 A parked, 2 B parked,
  // 3 comparing, 4 joint step, 5 dead.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  ph;
    logic [31:0] waited;  // cycles already spent parked waiting
    logic [31:0] held;    // compare cycles already elapsed
    logic [31:0] n;       // alignments so far (unbounded)
    logic [31:0] pc;
    logic        ok;
    logic        bad;
    logic        em;
    logic        et;
  } mdl_t;

  mdl_t m0 = '0;
  mdl_t m1 = '0;

  function automatic mdl_t mstep(mdl_t m, int T, int C, int W, bit S,
                                 bit a_s, bit b_s, logic [31:0] ap,
                                 logic [31:0] bp, logic [31:0] ia,
                                 logic [31:0] ib);
    mdl_t r;
    bit   go;
    r  = m;
    go = 1'b0;
    case (m.ph)
      3'd0: begin
        if (a_s && b_s) go = 1'b1;
        else if (a_s)   begin r.ph = 3'd1; r.waited = 0; end
        else if (b_s)   begin r.ph = 3'd2; r.waited = 0; end
      end
      3'd1, 3'd2: begin
        if ((m.ph == 3'd1) ? b_s : a_s) go = 1'b1;
        else if (int'(m.waited) + 1 >= T) begin r.ph = 3'd5; r.et = 1'b1; end
        else r.waited = m.waited + 1;
      end
      3'd3: begin
        r.held = m.held + 1;
        if (int'(r.held) >= C) r.ph = (m.bad && S) ? 3'd5 : 3'd4;
      end
      3'd4: r.ph = 3'd0;
      default: ;
    endcase
    if (go) begin
      r.ph   = 3'd3;
      r.held = 0;
      r.pc   = ap;
      r.bad  = (ap != bp) || (ia != ib);
      r.em   = m.em | r.bad;
      r.ok   = (int'(m.n) >= W) && !r.bad;
      r.n    = m.n + 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mstep(m0, 64, 2, 2, 1'b1, as, bs, apc, bpc, ai, bi);
      m1 <= mstep(m1, 8, 1, 0, 1'b0, as, bs, apc, bpc, ai, bi);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag, input mdl_t m, input int maxc,
                             input logic ae, input logic be, input logic cv,
                             input logic [31:0] cpc, input logic [31:0] cnt,
                             input logic em, input logic et, input logic h);
    logic ea, eb;
    ea = (m.ph == 3'd0 || m.ph == 3'd2) ? !as : (m.ph == 3'd4);
    eb = (m.ph == 3'd0 || m.ph == 3'd1) ? !bs : (m.ph == 3'd4);
    cmp({tag, ".a_en"}, 32'(ae), 32'(ea));
    cmp({tag, ".b_en"}, 32'(be), 32'(eb));
    cmp({tag, ".cmp_valid"}, 32'(cv), 32'(m.ph == 3'd3 && m.ok));
    cmp({tag, ".cmp_pc"}, cpc, m.pc);
    cmp({tag, ".align_cnt"}, cnt, (int'(m.n) > maxc) ? 32'(maxc) : m.n);
    cmp({tag, ".err_mismatch"}, 32'(em), 32'(m.em));
    cmp({tag, ".err_timeout"}, 32'(et), 32'(m.et));
    cmp({tag, ".halted"}, 32'(h), 32'(m.ph == 3'd5));
  endtask

  always @(negedge clk) begin
    check_model("dut0", m0, 65535, a_en0, b_en0, cv0, cpc0, 32'(cnt0), em0, et0, h0);
    check_model("dut1", m1, 15, a_en1, b_en1, cv1, cpc1, 32'(cnt1), em1, et1, h1);
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with hand-computed literal expectations (dut0 unless
  // named otherwise). Inputs change 1 time unit after posedge; literal
  // checks happen 2 units later, well before the negedge compare.
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #2;
  endtask

  // Both cores arrive together: RUN, ALIGN x2, RELEASE for dut0.
  task automatic pair();
    as = 1'b1; bs = 1'b1;
    tick(); tick(); tick();
    as = 1'b0; bs = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    as = 1'b0; bs = 1'b0;
    apc = 32'h0; bpc = 32'h0; ai = 32'h13; bi = 32'h13;
    tick(); tick(); tick();

    // Reset state
    peek();
    cmp("rst.align_cnt", 32'(cnt0), 32'h0);
    cmp("rst.cmp_pc", cpc0, 32'h0);
    cmp("rst.halted", 32'(h0), 32'h0);
    cmp("rst.cmp_valid", 32'(cv0), 32'h0);

    // Both starts high straight after reset
    tick();
    resetn = 1'b1; as = 1'b1; bs = 1'b1;
    peek();
    cmp("t1.gate_a", 32'(a_en0), 32'h0);
    cmp("t1.gate_b", 32'(b_en0), 32'h0);
    tick(); peek();
    cmp("t1.align_cnt", 32'(cnt0), 32'h1);
    cmp("t1.warm_valid", 32'(cv0), 32'h0);
    tick(); tick();
    as = 1'b0; bs = 1'b0;
    peek();
    cmp("t1.rel_a", 32'(a_en0), 32'h1);
    cmp("t1.rel_b", 32'(b_en0), 32'h1);
    tick();

    // Second warm-up alignment
    pair();

    // A at t, B at t+5, both PC 0x8
    apc = 32'h8; bpc = 32'h8; as = 1'b1; bs = 1'b0;
    peek();
    cmp("t2.a_gated_t", 32'(a_en0), 32'h0);
    cmp("t2.b_runs_t", 32'(b_en0), 32'h1);
    tick(); tick(); tick(); peek();
    cmp("t2.a_gated_t3", 32'(a_en0), 32'h0);
    tick(); tick();
    bs = 1'b1;
    peek();
    cmp("t2.b_gated_t5", 32'(b_en0), 32'h0);
    tick(); peek();
    cmp("t2.cmp_valid0", 32'(cv0), 32'h1);
    cmp("t2.cmp_pc", cpc0, 32'h8);
    cmp("t2.align_cnt", 32'(cnt0), 32'h3);
    cmp("t2.a_gated_t6", 32'(a_en0), 32'h0);
    tick(); peek();
    cmp("t2.cmp_valid1", 32'(cv0), 32'h1);
    cmp("t2.a_gated_t7", 32'(a_en0), 32'h0);
    tick();
    as = 1'b0; bs = 1'b0;
    peek();
    cmp("t2.rel_a", 32'(a_en0), 32'h1);
    cmp("t2.valid_off", 32'(cv0), 32'h0);
    tick();

    // PC mismatch halts dut0; dut1 records it and carries on
    apc = 32'h10; bpc = 32'h14; as = 1'b1; bs = 1'b1;
    tick(); peek();
    cmp("t3.err_mismatch", 32'(em0), 32'h1);
    cmp("t3.cmp_valid", 32'(cv0), 32'h0);
    cmp("t3.cmp_pc", cpc0, 32'h10);
    cmp("t3.not_yet_halted", 32'(h0), 32'h0);
    tick(); tick();
    as = 1'b0; bs = 1'b0;
    peek();
    cmp("t3.halted", 32'(h0), 32'h1);
    cmp("t3.halt_a", 32'(a_en0), 32'h0);
    cmp("t3.halt_b", 32'(b_en0), 32'h0);
    cmp("t3.dut1_err", 32'(em1), 32'h1);
    cmp("t3.dut1_running", 32'(h1), 32'h0);

    // Asynchronous reset out of HALT
    resetn = 1'b0;
    #1;
    cmp("r1.halted", 32'(h0), 32'h0);
    cmp("r1.err_mismatch", 32'(em0), 32'h0);
    cmp("r1.align_cnt", 32'(cnt0), 32'h0);
    cmp("r1.cmp_pc", cpc0, 32'h0);
    apc = 32'h0; bpc = 32'h0;
    tick(); tick();

    // A arrives, B never does
    resetn = 1'b1; as = 1'b1; bs = 1'b0;
    repeat (64) tick();
    peek();
    cmp("t4.no_halt_yet", 32'(h0), 32'h0);
    cmp("t4.no_err_yet", 32'(et0), 32'h0);
    tick(); peek();
    cmp("t4.halted", 32'(h0), 32'h1);
    cmp("t4.err_timeout", 32'(et0), 32'h1);
    resetn = 1'b0;
    #1;
    cmp("r2.err_timeout", 32'(et0), 32'h0);
    cmp("r2.halted", 32'(h0), 32'h0);
    as = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Counter saturation on the 4-bit instance
    repeat (20) pair();
    peek();
    cmp("t5.align_cnt", 32'(cnt0), 32'd20);
    cmp("t5.dut1_saturated", 32'(cnt1), 32'hF);

    // Reset pulsed in the middle of a compare window
    as = 1'b1; bs = 1'b1;
    tick(); peek();
    cmp("t6.valid_before", 32'(cv0), 32'h1);
    resetn = 1'b0;
    #1;
    cmp("t6.valid_dropped", 32'(cv0), 32'h0);
    cmp("t6.err_mismatch", 32'(em0), 32'h0);
    cmp("t6.err_timeout", 32'(et0), 32'h0);
    cmp("t6.align_cnt", 32'(cnt0), 32'h0);
    as = 1'b0; bs = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    pair();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lockstep_sync_ctrl
`default_nettype wire
